// File: rtl/or1200_vlx_store_sched_if.sv
// rtl/or1200_vlx_store_sched_if.sv - data-side bus port shared by the LSU and the VLX store path
interface or1200_vlx_store_sched_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        ack;
  logic [31:0] dat_r;

  modport master (output cyc, stb, we, adr, dat_w, sel, input ack, dat_r);
  modport slave  (input cyc, stb, we, adr, dat_w, sel, output ack, dat_r);
endinterface

// File: rtl/or1200_vlx_store_sched.sv
// rtl/or1200_vlx_store_sched.sv - VLX byte FIFO and round-robin store scheduler on the data bus
// OR1200_VLX_STUFF_EN: insert a 0x00 entry after every pushed 0xFF byte.
module or1200_vlx_store_sched #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 2,
  parameter logic [31:0] ADDR_RST = 32'h0383c1d0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        vlx_valid_i,
  input  logic [7:0]  vlx_byte_i,
  output logic        vlx_ready_o,
  input  logic        base_we_i,
  input  logic [31:0] base_dat_i,
  input  logic        flush_i,
  output logic [31:0] addr_o,
  output logic        stall_cpu_o,
  output logic        busy_o,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [31:0] lsu_adr_i,
  input  logic [31:0] lsu_dat_i,
  input  logic [3:0]  lsu_sel_i,
  output logic        lsu_ack_o,
  output logic [31:0] lsu_dat_o,
  or1200_vlx_store_sched_if.master bus
);
  typedef enum logic [1:0] {IDLE, LSU_CYC, VLX_CYC} state_t;
  state_t state_q, state_d;

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, push_n, pop_n;
  logic [7:0]    head;
  logic          push, pop, empty, full, stuff;
  logic          last_vlx, flush_pend;
  logic [31:0]   addr_q;
  logic          bus_cyc_q, bus_we_q;
  logic [31:0]   bus_adr_q, bus_dat_q;
  logic [3:0]    bus_sel_q;
  logic          lsu_ack_q;
  logic [31:0]   lsu_dat_q;
  logic          lsu_req, grant_lsu, grant_vlx;

`ifdef OR1200_VLX_STUFF_EN
  // a stuffed 0xFF needs two free slots, so full one entry early
  localparam logic [AW:0] FULL_LVL = DEPTH_C - {{AW{1'b0}}, 1'b1};
  assign stuff = (vlx_byte_i == 8'hFF);
`else
  localparam logic [AW:0] FULL_LVL = DEPTH_C;
  assign stuff = 1'b0;
`endif

  assign empty       = (count == '0);
  assign full        = (count >= FULL_LVL);
  assign vlx_ready_o = ~full;
  assign push        = vlx_valid_i & vlx_ready_o;
  assign pop         = (state_q == VLX_CYC) & bus.ack;
  assign push_n      = {{(AW-1){1'b0}}, push & stuff, push & ~stuff};
  assign pop_n       = {{AW{1'b0}}, pop};
  assign head        = mem[rd_ptr];

  assign busy_o      = ~empty | (state_q == VLX_CYC);
  assign stall_cpu_o = full | (flush_pend & busy_o);
  assign addr_o      = addr_q;
  assign lsu_ack_o   = lsu_ack_q;
  assign lsu_dat_o   = lsu_dat_q;
  assign bus.cyc     = bus_cyc_q;
  assign bus.stb     = bus_cyc_q;
  assign bus.we      = bus_we_q;
  assign bus.adr     = bus_adr_q;
  assign bus.dat_w   = bus_dat_q;
  assign bus.sel     = bus_sel_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + push_n[AW-1:0];
      rd_ptr <= rd_ptr + pop_n[AW-1:0];
      count  <= count + push_n - pop_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= vlx_byte_i;
      if (stuff) mem[wr_ptr + 1'b1] <= 8'h00;
    end
  end

  // the request still seen while the ack is out belongs to the finished transfer
  assign lsu_req   = lsu_req_i & ~lsu_ack_q;
  assign grant_lsu = lsu_req & (empty | last_vlx);
  assign grant_vlx = ~empty & (~lsu_req | ~last_vlx);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_lsu)      state_d = LSU_CYC;
        else if (grant_vlx) state_d = VLX_CYC;
      end
      LSU_CYC, VLX_CYC: if (bus.ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      last_vlx   <= 1'b1;
      addr_q     <= ADDR_RST;
      flush_pend <= 1'b0;
      bus_cyc_q  <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_adr_q  <= '0;
      bus_dat_q  <= '0;
      bus_sel_q  <= '0;
      lsu_ack_q  <= 1'b0;
      lsu_dat_q  <= '0;
    end else begin
      state_q   <= state_d;
      lsu_ack_q <= 1'b0;
      if (base_we_i) addr_q <= base_dat_i;
      else if (pop)  addr_q <= addr_q + 32'd1;
      if (flush_i)      flush_pend <= 1'b1;
      else if (!busy_o) flush_pend <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_lsu) begin
            bus_cyc_q <= 1'b1;
            bus_we_q  <= lsu_we_i;
            bus_adr_q <= lsu_adr_i;
            bus_dat_q <= lsu_dat_i;
            bus_sel_q <= lsu_sel_i;
          end else if (grant_vlx) begin
            bus_cyc_q <= 1'b1;
            bus_we_q  <= 1'b1;
            bus_adr_q <= addr_q;
            bus_dat_q <= {4{head}};
            bus_sel_q <= 4'b1000 >> addr_q[1:0];
          end
        end
        LSU_CYC, VLX_CYC: begin
          if (bus.ack) begin
            bus_cyc_q <= 1'b0;
            bus_we_q  <= 1'b0;
            bus_adr_q <= '0;
            bus_dat_q <= '0;
            bus_sel_q <= '0;
            last_vlx  <= (state_q == VLX_CYC);
            if (state_q == LSU_CYC) begin
              lsu_ack_q <= 1'b1;
              lsu_dat_q <= bus.dat_r;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_or1200_vlx_store_sched.sv
// tb/tb_or1200_vlx_store_sched.sv - directed self-checking bench for the VLX store scheduler
`timescale 1ns/1ps
module tb_or1200_vlx_store_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vlx_valid = 1'b0;
  logic [7:0]  vlx_byte = 8'h00;
  logic        vlx_ready;
  logic        base_we = 1'b0;
  logic [31:0] base_dat = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] addr;
  logic        stall, busy;
  logic        lsu_req = 1'b0, lsu_we = 1'b0;
  logic [31:0] lsu_adr = 32'h0, lsu_dat = 32'h0;
  logic [3:0]  lsu_sel = 4'h0;
  logic        lsu_ack;
  logic [31:0] lsu_rdat;

  or1200_vlx_store_sched_if bus_if ();

  or1200_vlx_store_sched dut (
    .clk_i(clk), .rst_i(rst),
    .vlx_valid_i(vlx_valid), .vlx_byte_i(vlx_byte), .vlx_ready_o(vlx_ready),
    .base_we_i(base_we), .base_dat_i(base_dat), .flush_i(flush),
    .addr_o(addr), .stall_cpu_o(stall), .busy_o(busy),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_adr_i(lsu_adr), .lsu_dat_i(lsu_dat),
    .lsu_sel_i(lsu_sel), .lsu_ack_o(lsu_ack), .lsu_dat_o(lsu_rdat),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

`ifdef OR1200_VLX_STUFF_EN
  localparam int N_FILL = 3;
  localparam int N_ST   = 3;
  logic [7:0] st_b [3] = '{8'hFF, 8'h00, 8'h12};
`else
  localparam int N_FILL = 4;
  localparam int N_ST   = 2;
  logic [7:0] st_b [3] = '{8'hFF, 8'h12, 8'h00};
`endif
  logic [7:0] fill_b   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [3:0] fill_sel [4] = '{4'h4, 4'h2, 4'h1, 4'h8};
  logic [3:0] st_sel   [3] = '{4'h8, 4'h4, 4'h2};

  int total = 0;
  int bad = 0;
  int ack_cnt = 0;
  logic [31:0] s_adr, s_dat;
  logic [3:0]  s_sel;
  logic        s_we;
  logic [31:0] exp_a;

  always @(negedge clk) if (lsu_ack === 1'b1) ack_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    vlx_valid = 1'b1;
    vlx_byte  = b;
    @(negedge clk);
    vlx_valid = 1'b0;
  endtask

  // waits for a bus cycle, captures it, acks after wait_n extra cycles
  task automatic serve(input int wait_n, input logic with_base, input logic [31:0] rdat);
    int n = 0;
    while (bus_if.cyc !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cyc_seen", bus_if.cyc, 32'd1);
    check("stb", bus_if.stb, 32'd1);
    s_adr = bus_if.adr;
    s_dat = bus_if.dat_w;
    s_sel = bus_if.sel;
    s_we  = bus_if.we;
    repeat (wait_n) @(negedge clk);
    bus_if.ack   = 1'b1;
    bus_if.dat_r = rdat;
    if (with_base) begin
      base_we  = 1'b1;
      base_dat = 32'h200;
    end
    @(negedge clk);
    bus_if.ack = 1'b0;
    base_we    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus_if.ack   = 1'b0;
    bus_if.dat_r = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_cyc", bus_if.cyc, 32'd0);
    check("rst_stb", bus_if.stb, 32'd0);
    check("rst_we", bus_if.we, 32'd0);
    check("rst_adr", bus_if.adr, 32'd0);
    check("rst_dat", bus_if.dat_w, 32'd0);
    check("rst_sel", bus_if.sel, 32'd0);
    check("rst_lsu_ack", lsu_ack, 32'd0);
    check("rst_lsu_dat", lsu_rdat, 32'd0);
    check("rst_stall", stall, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_ready", vlx_ready, 32'd1);
    check("rst_addr", addr, 32'h0383c1d0);
    rst = 1'b0;
    @(negedge clk);

    // single store, ack two cycles into the strobe
    base_we = 1'b1; base_dat = 32'h100;
    @(negedge clk);
    base_we = 1'b0;
    check("base_load", addr, 32'h100);
    push(8'hA5);
    serve(1, 1'b0, 32'h0);
    check("t1_adr", s_adr, 32'h100);
    check("t1_sel", s_sel, 32'h8);
    check("t1_dat", s_dat, 32'hA5A5A5A5);
    check("t1_we", s_we, 32'd1);
    check("t1_addr_inc", addr, 32'h101);
    check("t1_cyc_low", bus_if.cyc, 32'd0);
    check("t1_busy_low", busy, 32'd0);

    // fill the FIFO with the bus held off
    for (int i = 0; i < N_FILL; i++) push(fill_b[i]);
    check("t2_ready_full", vlx_ready, 32'd0);
    check("t2_stall_full", stall, 32'd1);
    check("t2_busy", busy, 32'd1);
    for (int i = 0; i < N_FILL; i++) begin
      serve(0, 1'b0, 32'h0);
      check("t2_adr", s_adr, 32'h101 + i);
      check("t2_dat", s_dat, {4{fill_b[i]}});
      check("t2_sel", s_sel, fill_sel[i]);
      if (i == 0) begin
        check("t2_ready_after_ack", vlx_ready, 32'd1);
        check("t2_stall_after_ack", stall, 32'd0);
      end
    end

    // address load racing a VLX ack
    exp_a = 32'h101 + N_FILL;
    push(8'h77);
    serve(1, 1'b1, 32'h0);
    check("t3_adr_old", s_adr, exp_a);
    check("t3_base_wins", addr, 32'h200);
    push(8'h88);
    serve(1, 1'b0, 32'h0);
    check("t3_adr_new", s_adr, 32'h200);
    check("t3_sel_new", s_sel, 32'h8);
    check("t3_dat_new", s_dat, 32'h88888888);
    check("t3_addr_inc", addr, 32'h201);

    // byte stuffing
    base_we = 1'b1; base_dat = 32'h300;
    @(negedge clk);
    base_we = 1'b0;
    push(8'hFF);
    push(8'h12);
    for (int i = 0; i < N_ST; i++) begin
      serve(0, 1'b0, 32'h0);
      check("t5_adr", s_adr, 32'h300 + i);
      check("t5_dat", s_dat, {4{st_b[i]}});
      check("t5_sel", s_sel, st_sel[i]);
    end
    check("t5_busy_done", busy, 32'd0);
    check("t5_addr_end", addr, 32'h300 + N_ST);

    // flush drains three bytes with the CPU held
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t6_stall_flush", stall, 32'd1);
    serve(0, 1'b0, 32'h0);
    check("t6_stall_ack1", stall, 32'd1);
    serve(0, 1'b0, 32'h0);
    check("t6_stall_ack2", stall, 32'd1);
    serve(0, 1'b0, 32'h0);
    check("t6_dat3", s_dat, 32'hA3A3A3A3);
    check("t6_busy_ack3", busy, 32'd0);
    check("t6_stall_ack3", stall, 32'd0);
    @(negedge clk);
    check("t6_stall_after", stall, 32'd0);

    // round-robin from reset with both sources pending
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_adr = 32'h4000; lsu_sel = 4'hF;
    vlx_valid = 1'b1; vlx_byte = 8'hB1;
    @(negedge clk);
    vlx_byte = 8'hB2;
    @(negedge clk);
    vlx_valid = 1'b0;
    serve(0, 1'b0, 32'hCAFEF00D);
    check("t4_1_we", s_we, 32'd0);
    check("t4_1_adr", s_adr, 32'h4000);
    check("t4_1_sel", s_sel, 32'hF);
    check("t4_1_ack", lsu_ack, 32'd1);
    check("t4_1_rdat", lsu_rdat, 32'hCAFEF00D);
    lsu_adr = 32'h4004;
    serve(0, 1'b0, 32'h0);
    check("t4_2_we", s_we, 32'd1);
    check("t4_2_adr", s_adr, 32'h0383c1d0);
    check("t4_2_dat", s_dat, 32'hB1B1B1B1);
    check("t4_2_ack_low", lsu_ack, 32'd0);
    serve(0, 1'b0, 32'h12345678);
    check("t4_3_we", s_we, 32'd0);
    check("t4_3_adr", s_adr, 32'h4004);
    check("t4_3_rdat", lsu_rdat, 32'h12345678);
    lsu_req = 1'b0;
    serve(0, 1'b0, 32'h0);
    check("t4_4_we", s_we, 32'd1);
    check("t4_4_dat", s_dat, 32'hB2B2B2B2);
    check("t4_4_sel", s_sel, 32'h4);
    check("t4_ack_pulses", ack_cnt, 32'd2);
    check("t4_busy_done", busy, 32'd0);

    // reset in the middle of a VLX cycle
    push(8'hC3);
    @(negedge clk);
    check("t7_cyc_up", bus_if.cyc, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t7_cyc_async", bus_if.cyc, 32'd0);
    check("t7_busy_async", busy, 32'd0);
    check("t7_ready_async", vlx_ready, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t7_no_store", bus_if.cyc, 32'd0);
    check("t7_busy_idle", busy, 32'd0);
    check("t7_addr_rst", addr, 32'h0383c1d0);
    check("t7_no_ack", ack_cnt, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
